// File: rtl/sccb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sccb_pkg                                                                 |
// | Shared types and constants for the SCCB responder: FSM state encoding,   |
// | bits per SCCB phase, OV7670 bus IDs and the device ID compare helper.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package sccb_pkg;

  // Eight data bits plus one ACK/NA bit per phase.
  localparam int unsigned SCCB_BITS_PER_PHASE = 9;

  // Index of the last data bit inside a phase (bit counter value 7).
  localparam logic [2:0] SCCB_LAST_DATA_BIT = 3'(SCCB_BITS_PER_PHASE - 2);

  localparam logic [7:0] OV7670_WR_ID = 8'h42;
  localparam logic [7:0] OV7670_RD_ID = 8'h43;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_ID_ACK    = 4'd2,
    ST_SUBADDR   = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RD_NA     = 4'd8,
    ST_IGNORE    = 4'd9
  } sccb_tgt_state_t;

  // The R/W bit (bit 0) is not part of the address compare.
  function automatic logic id_match(input logic [7:0] rx_id, input logic [7:0] dev_id);
    return rx_id[7:1] == dev_id[7:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_target_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sccb_target_if                                                           |
// | Bus and host-side signals of the SCCB responder.                         |
// |   scl        : serial clock from the master                              |
// |   sda        : resolved level of the open-drain data line                 |
// |   sda_oe     : responder pulls sda low while high (pad = oe ? 0 : z)      |
// |   busy       : start seen, stop not yet seen                              |
// |   wr_valid/wr_addr/wr_data : one-cycle notice per written byte            |
// |   host_addr/host_rdata     : local register-file read port                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface sccb_target_if;
  logic       scl;
  logic       sda;
  logic       sda_oe;
  logic       busy;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] host_addr;
  logic [7:0] host_rdata;

  modport slave (
    input  scl, sda, host_addr,
    output sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata
  );

  modport master (
    output scl, sda, host_addr,
    input  sda_oe, busy, wr_valid, wr_addr, wr_data, host_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sccb_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sccb_line_sync                                                           |
// | 2-FF synchronizers plus registered rise/fall detectors for scl and sda.  |
// | Ports: sysclk, rst; scl_i/sda_i raw pins; scl_o/sda_o synchronized       |
// | levels; *_rise_o/*_fall_o one-cycle edge pulses aligned with the levels. |
// | Pin-to-pulse latency is 3 sysclk.                                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sccb_line_sync
  import sccb_pkg::*;
(
  input  logic sysclk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic sda_rise_o,
  output logic sda_fall_o
);

  // [1:0] are the synchronizer, [2] is the previous-value tap for edges.
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;
  logic       scl_rise_q, scl_fall_q, sda_rise_q, sda_fall_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      // Reset to the idle bus level so no spurious edge follows reset.
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      sda_rise_q <= 1'b0;
      sda_fall_q <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_i};
      sda_sync_q <= {sda_sync_q[1:0], sda_i};
      scl_rise_q <=  scl_sync_q[1] & ~scl_sync_q[2];
      scl_fall_q <= ~scl_sync_q[1] &  scl_sync_q[2];
      sda_rise_q <=  sda_sync_q[1] & ~sda_sync_q[2];
      sda_fall_q <= ~sda_sync_q[1] &  sda_sync_q[2];
    end
  end

  assign scl_o      = scl_sync_q[2];
  assign sda_o      = sda_sync_q[2];
  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign sda_rise_o = sda_rise_q;
  assign sda_fall_o = sda_fall_q;

endmodule
`default_nettype wire

// File: rtl/sccb_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sccb_target                                                              |
// | SCCB responder: decodes start/stop/ID/sub-address/data phases, ACKs      |
// | writes into a 256x8 register file and serves reads from the pointer      |
// | set by a preceding write phase.                                          |
// | Ports: sysclk, rst (sync, active-high); bus (sccb_target_if.slave).      |
// | Parameter: DEVICE_ID - 8-bit write ID, bits [7:1] compared.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sccb_target
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = OV7670_WR_ID
) (
  input  logic               sysclk,
  input  logic               rst,
  sccb_target_if.slave       bus
);

  logic scl_lvl, sda_lvl, scl_rise, scl_fall, sda_rise, sda_fall;

  sccb_line_sync u_line_sync (
    .sysclk     (sysclk),
    .rst        (rst),
    .scl_i      (bus.scl),
    .sda_i      (bus.sda),
    .scl_o      (scl_lvl),
    .sda_o      (sda_lvl),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .sda_rise_o (sda_rise),
    .sda_fall_o (sda_fall)
  );

  // sda edges count as start/stop only while the synchronized scl is high.
  logic start_det, stop_det;
  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  sccb_tgt_state_t state_q;
  logic [2:0] bitcnt_q;
  logic       last_q;       // eighth data bit of the phase has been sampled
  logic       rnw_q;
  logic       nack_q;
  logic [6:0] shift_q;      // received bits so far
  logic [6:0] tx_q;         // read bits still to be sent after the current one
  logic [7:0] ptr_q;
  logic       sda_oe_q, busy_q;
  logic       wr_valid_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [7:0] host_rdata_q;
  logic [7:0] mem_q [256];

  logic [7:0] rx_byte_d, ptr_inc_d, cur_byte_d, next_byte_d;
  logic       byte_done_d;
  assign rx_byte_d   = {shift_q, sda_lvl};
  assign ptr_inc_d   = ptr_q + 8'd1;
  assign cur_byte_d  = mem_q[ptr_q];
  assign next_byte_d = mem_q[ptr_inc_d];
  assign byte_done_d = (bitcnt_q == SCCB_LAST_DATA_BIT);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= '0;
      last_q     <= 1'b0;
      rnw_q      <= 1'b0;
      nack_q     <= 1'b0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q  <= ST_ID;
        bitcnt_q <= '0;
        last_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b1;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        last_q   <= 1'b0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_ID, ST_SUBADDR, ST_WDATA: begin
            if (scl_rise) begin
              shift_q  <= rx_byte_d[6:0];
              bitcnt_q <= bitcnt_q + 3'd1;
              last_q   <= byte_done_d;
              if (byte_done_d) begin
                case (state_q)
                  ST_ID: begin
                    if (!id_match(rx_byte_d, DEVICE_ID)) state_q <= ST_IGNORE;
                    rnw_q <= rx_byte_d[0];
                  end
                  ST_SUBADDR: ptr_q <= rx_byte_d;
                  default: begin
                    wr_valid_q <= 1'b1;
                    wr_addr_q  <= ptr_q;
                    wr_data_q  <= rx_byte_d;
                    ptr_q      <= ptr_inc_d;
                  end
                endcase
              end
            end else if (scl_fall && last_q) begin
              // Falling scl after bit 8: hold sda low for the whole 9th bit.
              last_q   <= 1'b0;
              sda_oe_q <= 1'b1;
              case (state_q)
                ST_ID:      state_q <= ST_ID_ACK;
                ST_SUBADDR: state_q <= ST_SUB_ACK;
                default:    state_q <= ST_WDATA_ACK;
              endcase
            end
          end
          ST_ID_ACK: begin
            if (scl_fall) begin
              bitcnt_q <= '0;
              if (rnw_q) begin
                // Release the ACK and present the read MSB on the same edge.
                state_q  <= ST_RDATA;
                sda_oe_q <= ~cur_byte_d[7];
                tx_q     <= cur_byte_d[6:0];
              end else begin
                state_q  <= ST_SUBADDR;
                sda_oe_q <= 1'b0;
              end
            end
          end
          ST_SUB_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              state_q  <= ST_WDATA;
              bitcnt_q <= '0;
              sda_oe_q <= 1'b0;
            end
          end
          ST_RDATA: begin
            if (scl_rise) begin
              bitcnt_q <= bitcnt_q + 3'd1;
              last_q   <= byte_done_d;
            end else if (scl_fall) begin
              if (last_q) begin
                last_q   <= 1'b0;
                state_q  <= ST_RD_NA;
                sda_oe_q <= 1'b0;
              end else begin
                sda_oe_q <= ~tx_q[6];
                tx_q     <= {tx_q[5:0], 1'b0};
              end
            end
          end
          ST_RD_NA: begin
            if (scl_rise) begin
              nack_q <= sda_lvl;
            end else if (scl_fall) begin
              bitcnt_q <= '0;
              if (nack_q) begin
                state_q <= ST_IGNORE;
              end else begin
                state_q  <= ST_RDATA;
                ptr_q    <= ptr_inc_d;
                sda_oe_q <= ~next_byte_d[7];
                tx_q     <= next_byte_d[6:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read-first register file: host_rdata sees the pre-write value on a
  // same-cycle address collision.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= '0;
      host_rdata_q <= '0;
    end else begin
      host_rdata_q <= mem_q[bus.host_addr];
      if (wr_valid_q) mem_q[wr_addr_q] <= wr_data_q;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.busy       = busy_q;
  assign bus.wr_valid   = wr_valid_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.host_rdata = host_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_target.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sccb_target                                                           |
// | Self-checking bench for sccb_target: table of write transactions plus    |
// | hand-written read, burst-wrap, repeated-start and reset sequences.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sccb_target;
  import sccb_pkg::*;

  localparam int Q = 8;  // sysclk cycles per quarter scl period

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sccb_target_if bus ();
  logic m_scl, m_sda;
  assign bus.scl = m_scl;
  assign bus.sda = m_sda & ~bus.sda_oe;  // open-drain wired-AND

  sccb_target #(.DEVICE_ID(OV7670_WR_ID)) dut (
    .sysclk (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wr_a_log [$];
  logic [7:0] wr_d_log [$];
  int         oe_cycles = 0;

  always @(negedge clk) begin
    if (bus.wr_valid) begin
      wr_a_log.push_back(bus.wr_addr);
      wr_d_log.push_back(bus.wr_data);
    end
    if (bus.sda_oe) oe_cycles++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    m_sda = 1'b1; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0; tick(Q);
    m_scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic do_bit(input logic b, output logic s);
    m_sda = b;    tick(Q);
    m_scl = 1'b1; tick(Q);
    s = bus.sda;  tick(Q);
    m_scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack_n);
    logic s;
    for (int i = 7; i >= 0; i--) do_bit(b[i], s);
    do_bit(1'b1, ack_n);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      do_bit(1'b1, s);
      d[i] = s;
    end
    do_bit(nack, s);
  endtask

  task automatic host_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    bus.host_addr = a;
    tick(2);
    check(name, 32'(bus.host_rdata), 32'(exp));
  endtask

  typedef struct {
    logic [7:0] id;
    logic [7:0] sub;
    logic [7:0] data;
    logic       exp_ack_n;  // level seen on every 9th bit
    int         exp_nwr;    // wr_valid pulses expected
    logic [7:0] exp_rd;     // reg[sub] afterwards
  } vec_t;

  vec_t vecs [5];
  logic a0, a1, a2, a3;
  logic [7:0] rd;
  int wb, ob;

  initial begin
    vecs[0] = '{id: 8'h42, sub: 8'h12, data: 8'h80, exp_ack_n: 1'b0, exp_nwr: 1, exp_rd: 8'h80};
    vecs[1] = '{id: 8'h60, sub: 8'h12, data: 8'h55, exp_ack_n: 1'b1, exp_nwr: 0, exp_rd: 8'h80};
    vecs[2] = '{id: 8'h42, sub: 8'h0A, data: 8'h76, exp_ack_n: 1'b0, exp_nwr: 1, exp_rd: 8'h76};
    vecs[3] = '{id: 8'h41, sub: 8'h0A, data: 8'h11, exp_ack_n: 1'b1, exp_nwr: 0, exp_rd: 8'h76};
    vecs[4] = '{id: 8'h42, sub: 8'h05, data: 8'hC3, exp_ack_n: 1'b0, exp_nwr: 1, exp_rd: 8'hC3};

    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1; bus.host_addr = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst_sda_oe",     32'(bus.sda_oe),     0);
    check("rst_busy",       32'(bus.busy),       0);
    check("rst_wr_valid",   32'(bus.wr_valid),   0);
    check("rst_wr_addr",    32'(bus.wr_addr),    0);
    check("rst_wr_data",    32'(bus.wr_data),    0);
    check("rst_host_rdata", 32'(bus.host_rdata), 0);
    check("rst_state",      32'(dut.state_q),    32'(ST_IDLE));

    // Table-driven single-byte write transactions.
    for (int v = 0; v < 5; v++) begin
      wb = wr_a_log.size();
      ob = oe_cycles;
      do_start();
      check("busy_after_start", 32'(bus.busy), 1);
      send_byte(vecs[v].id, a0);
      send_byte(vecs[v].sub, a1);
      send_byte(vecs[v].data, a2);
      do_stop();
      check("busy_after_stop", 32'(bus.busy), 0);
      check("ack_id",   32'(a0), 32'(vecs[v].exp_ack_n));
      check("ack_sub",  32'(a1), 32'(vecs[v].exp_ack_n));
      check("ack_data", 32'(a2), 32'(vecs[v].exp_ack_n));
      check("wr_count", 32'(wr_a_log.size() - wb), 32'(vecs[v].exp_nwr));
      if (vecs[v].exp_nwr == 1 && wr_a_log.size() > wb) begin
        check("wr_addr", 32'(wr_a_log[wb]), 32'(vecs[v].sub));
        check("wr_data", 32'(wr_d_log[wb]), 32'(vecs[v].data));
      end
      if (vecs[v].exp_nwr == 0) check("oe_never_on_mismatch", 32'(oe_cycles - ob), 0);
      host_read(vecs[v].sub, vecs[v].exp_rd, "host_rdata");
    end

    // Read of reg[0x0A]=0x76 after setting the pointer with a write phase.
    wb = wr_a_log.size();
    do_start(); send_byte(8'h42, a0); send_byte(8'h0A, a1); do_stop();
    do_start(); send_byte(8'h43, a2); recv_byte(1'b1, rd); do_stop();
    check("rd_ptr_ack", 32'({a0, a1}), 0);
    check("rd_id_ack",  32'(a2), 0);
    check("rd_data",    32'(rd), 32'h76);
    check("rd_no_wr",   32'(wr_a_log.size() - wb), 0);

    // Burst write wrapping the pointer from 0xFF to 0x00.
    wb = wr_a_log.size();
    do_start();
    send_byte(8'h42, a0); send_byte(8'hFF, a1); send_byte(8'h11, a2); send_byte(8'h22, a3);
    do_stop();
    check("burst_acks",  32'({a0, a1, a2, a3}), 0);
    check("burst_count", 32'(wr_a_log.size() - wb), 2);
    if (wr_a_log.size() >= wb + 2) begin
      check("burst_addr0", 32'(wr_a_log[wb]),     32'hFF);
      check("burst_addr1", 32'(wr_a_log[wb + 1]), 32'h00);
    end
    host_read(8'hFF, 8'h11, "burst_reg_ff");
    host_read(8'h00, 8'h22, "burst_reg_00");

    // Repeated start: pointer write then read without an intervening stop.
    do_start(); send_byte(8'h42, a0); send_byte(8'h05, a1);
    do_start(); send_byte(8'h43, a2); recv_byte(1'b1, rd); do_stop();
    check("rs_acks", 32'({a0, a1, a2}), 0);
    check("rs_data", 32'(rd), 32'hC3);

    // Reset while the responder drives a 0 read bit (MSB of 0x76).
    do_start(); send_byte(8'h42, a0); send_byte(8'h0A, a1); do_stop();
    do_start(); send_byte(8'h43, a2);
    m_sda = 1'b1; tick(Q);
    check("rst_mid_driving", 32'(bus.sda_oe), 1);
    m_scl = 1'b1; tick(2);
    rst = 1'b1; tick(1);
    check("rst_mid_sda_oe", 32'(bus.sda_oe),   0);
    check("rst_mid_busy",   32'(bus.busy),     0);
    check("rst_mid_state",  32'(dut.state_q),  32'(ST_IDLE));
    rst = 1'b0;
    tick(Q);

    wb = wr_a_log.size();
    do_start(); send_byte(8'h42, a0); send_byte(8'h33, a1); send_byte(8'h99, a2); do_stop();
    check("post_rst_acks",  32'({a0, a1, a2}), 0);
    check("post_rst_count", 32'(wr_a_log.size() - wb), 1);
    host_read(8'h33, 8'h99, "post_rst_reg_33");
    host_read(8'h0A, 8'h00, "post_rst_reg_0a_cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sccb_target.md
# sccb_target

SCCB responder: the camera end of the bus, driven by the team's SCCB master. It oversamples `scl`/`sda` on `sysclk` and decodes start, stop, ID, sub-address and data phases. It keeps a 256×8 register file, ACKs writes, and serves reads with the pointer set by a preceding write phase. It is used as an OV7670 register model in simulation and as a loopback target on the PYNQ board.

## Interface
- `DEVICE_ID`, 8'h42: 8-bit write ID. Read ID is `DEVICE_ID | 1`. Only bits [7:1] are compared.
- `sysclk` in 1: system clock, 125 MHz nominal.
- `rst` in 1: one clock; reset is synchronous and active-high.
- `scl` in 1: serial clock from master.
- `sda` inout 1: serial data. Responder drives only 1'b0 or 1'bz.
- `sda_oe` out 1: high while the responder pulls `sda` low or drives read data.
- `busy` out 1: high from detected start until detected stop.
- `wr_valid` out 1: one-cycle pulse per accepted write-data byte.
- `wr_addr` out 8: register address of the current `wr_valid`.
- `wr_data` out 8: data of the current `wr_valid`.
- `host_addr` in 8: local register-file read address.
- `host_rdata` out 8: `reg[host_addr]`, registered.

## Operation
- `scl` and `sda` pass through 2-FF synchronizers, then a 1-cycle edge detector.
- Start: `sda` falls while `scl` is high. Stop: `sda` rises while `scl` is high.
- Data is sampled on `scl` rising edges. Responder outputs change on the first `sysclk` after a detected `scl` falling edge.
- States:
  - IDLE
  - ID (8 bits) → ID_ACK
  - SUBADDR → SUB_ACK
  - WDATA → WDATA_ACK
  - RDATA → RD_NA
  - IGNORE
- A 3-bit bit counter resets on every start and on each ACK phase.
- Start in any state, including a repeated start: go to ID, bit counter 0, release `sda`.
- Stop in any state: go to IDLE, release `sda`. The pointer is kept.
- ID decode:
  - ID[7:1] ≠ DEVICE_ID[7:1] → IGNORE until stop. No ACK, no writes.
  - Match with R/W=0 → ACK, then SUBADDR.
  - Match with R/W=1 → ACK, then RDATA.
- ACK: drive `sda`=0 for the whole 9th bit. Assert from the falling `scl` after bit 8; release at the falling `scl` after bit 9.
- SUBADDR: byte → `ptr`, ACK, then WDATA.
- WDATA: per byte, write `reg[ptr]` ← byte and pulse `wr_valid`/`wr_addr`/`wr_data` one cycle after the 8th rising-`scl` sample. ACK, `ptr` ← `ptr`+1 mod 256, stay in WDATA.
- RDATA:
  - Shift out `reg[ptr]` MSB first. A 1 is sent as `sda` released (z), a 0 as drive-low.
  - At bit 9, release `sda` and sample the master's bit.
  - Master bit 1 (NA): IGNORE until stop.
  - Master bit 0: `ptr`+1 and send the next byte.
- The register file is read-first. A host read at the same address as an SCCB write in the same cycle returns the old value.

## Timing
- Reset values: state IDLE, `ptr` 0, `sda_oe` 0 (`sda`=z), `busy` 0, `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `host_rdata` 0, all 256 registers 8'h00.
- Latency, pin edge to internal event: 3 `sysclk` (2 sync + 1 edge detect).
- Pin `scl` falling edge → `sda`/`sda_oe` update: 4 `sysclk`. This is well inside the master's quarter-period setup margin (≈156 cycles at 200 kHz).
- Pin start/stop edge → `busy` change: 4 `sysclk`.
- `host_addr` → `host_rdata`: 1 `sysclk`.
- Reset mid-transfer releases `sda` on the cycle after `rst` is sampled. The bus resumes at the next start.
- `scl` and `sda` changing in the same `sysclk`: `sda` edges are qualified by synchronized `scl`=1. An `sda` change with `scl` low is never a start or stop.

## Structure
- `sccb_pkg` holds:
  - the state enum `sccb_tgt_state_t`
  - `SCCB_BITS_PER_PHASE` = 9
  - `OV7670_WR_ID` = 8'h42 and `OV7670_RD_ID` = 8'h43
- Sub-module `sccb_line_sync` contains the 2-FF synchronizers and rise/fall detectors for `scl` and `sda`.
- `sccb_target` holds the FSM, the shift registers, `ptr` and the register file.

## Test plan
- Write: start, 0x42, 0x12, 0x80, stop → `sda`=0 on all three 9th bits; one `wr_valid` with `wr_addr`=0x12, `wr_data`=0x80; `host_addr`=0x12 then gives 0x80.
- Read: preload `reg[0x0A]`=0x76. Send start, 0x42, 0x0A, stop, then start, 0x43, 8 clocks, master NA=1, stop → bits 0,1,1,1,0,1,1,0 on `sda`; no `wr_valid`.
- ID mismatch: start, 0x60, 0x12, 0x55, stop → `sda_oe` never 1; `reg[0x12]` unchanged; `busy` still toggles.
- Burst wrap: start, 0x42, 0xFF, 0x11, 0x22, stop → `reg[0xFF]`=0x11, `reg[0x00]`=0x22; `wr_addr` sequence 0xFF, 0x00.
- Repeated start: start, 0x42, 0x05, repeated start, 0x43 → `reg[0x05]` is read with no stop in between.
- Reset mid-read: assert `rst` while a 0 bit is being driven → `sda_oe`=0 the next cycle; state IDLE; `busy`=0; next full write transaction succeeds.
